// File: rtl/l1_pool_pkg.sv
// Shared constants and FSM state type for the layer-1 2x2 max-pool readout.
package l1_pool_pkg;
    localparam int DW       = 16;
    localparam int LINE_LEN = 24;
    localparam int PAIRS    = 26;
    localparam int ADDR_W   = 5;
    localparam int COL_W    = 4;
    localparam int PAIR_W   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/l1_smax2.sv
// Combinational signed two-input maximum; equal inputs return either value.
module l1_smax2
    import l1_pool_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y
);
    assign y = ($signed(a) >= $signed(b)) ? a : b;
endmodule

// File: rtl/l1_pool_rd.sv
// Reads two pool line buffers in lockstep and emits 2x2 signed maxima,
// tracking line pairs per frame and flagging starts that arrive while busy.
module l1_pool_rd
    import l1_pool_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             ConvValid_i,
    input  logic             start_i,
    output logic             rd_en_o,
    output logic [4:0]       rd_addr_o,
    input  logic [DW-1:0]    line0_d_i,
    input  logic [DW-1:0]    line1_d_i,
    output logic [DW-1:0]    pool_d_o,
    output logic             pool_vld_o,
    output logic [3:0]       pool_idx_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             overrun_o
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_LEN - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(LINE_LEN / 2 - 1);
    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(PAIRS - 1);

    state_t              state_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                rd_en_r;
    logic                busy_r;
    logic                overrun_r;
    logic                d1_vld_r;
    logic [ADDR_W-1:0]   d1_addr_r;
    logic [DW-1:0]       hold_r;
    logic [DW-1:0]       pool_d_r;
    logic [COL_W-1:0]    pool_idx_r;
    logic                pool_vld_r;
    logic                frame_done_r;
    logic [PAIR_W-1:0]   pair_r;
    logic [DW-1:0]       vmax_s;
    logic [DW-1:0]       hmax_s;

    l1_smax2 u_vmax (.a(line0_d_i), .b(line1_d_i), .y(vmax_s));
    l1_smax2 u_hmax (.a(hold_r),    .b(vmax_s),    .y(hmax_s));

    // Readout sequencer: address generation, read enable, busy and overrun flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= IDLE;
            addr_r    <= 5'd0;
            rd_en_r   <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else if (!ConvValid_i) begin
            state_r   <= IDLE;
            rd_en_r   <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (start_i && (state_r != IDLE)) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        state_r <= READ;
                        addr_r  <= 5'd0;
                        rd_en_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    if (addr_r == LAST_ADDR) begin
                        state_r <= DRAIN;
                        rd_en_r <= 1'b0;
                    end else begin
                        addr_r <= addr_r + 5'd1;
                    end
                end
                DRAIN: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    rd_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Data pipeline: hold the even-column vertical max, pool on the odd column.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d1_vld_r     <= 1'b0;
            d1_addr_r    <= 5'd0;
            hold_r       <= 16'd0;
            pool_d_r     <= 16'd0;
            pool_idx_r   <= 4'd0;
            pool_vld_r   <= 1'b0;
            frame_done_r <= 1'b0;
            pair_r       <= 5'd0;
        end else if (!ConvValid_i) begin
            d1_vld_r     <= 1'b0;
            hold_r       <= 16'd0;
            pool_vld_r   <= 1'b0;
            frame_done_r <= 1'b0;
            pair_r       <= 5'd0;
        end else begin
            d1_vld_r     <= rd_en_r;
            d1_addr_r    <= addr_r;
            pool_vld_r   <= 1'b0;
            frame_done_r <= 1'b0;
            if (d1_vld_r && !d1_addr_r[0]) begin
                hold_r <= vmax_s;
            end else if (d1_vld_r) begin
                pool_d_r   <= hmax_s;
                pool_idx_r <= d1_addr_r[4:1];
                pool_vld_r <= 1'b1;
                if (d1_addr_r[4:1] == LAST_COL) begin
                    if (pair_r == LAST_PAIR) begin
                        pair_r       <= 5'd0;
                        frame_done_r <= 1'b1;
                    end else begin
                        pair_r <= pair_r + 5'd1;
                    end
                end else begin
                    pair_r <= pair_r;
                end
            end else begin
                hold_r <= hold_r;
            end
        end
    end

    assign rd_en_o      = rd_en_r;
    assign rd_addr_o    = addr_r;
    assign busy_o       = busy_r;
    assign overrun_o    = overrun_r;
    assign pool_d_o     = pool_d_r;
    assign pool_idx_o   = pool_idx_r;
    assign pool_vld_o   = pool_vld_r;
    assign frame_done_o = frame_done_r;
endmodule

// File: tb/tb_l1_pool_rd.sv
// Directed self-checking bench for l1_pool_rd with a registered line-buffer model.
module tb_l1_pool_rd;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        conv_valid = 1'b0;
    logic        start = 1'b0;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [15:0] line0_d = 16'd0;
    logic [15:0] line1_d = 16'd0;
    logic [15:0] pool_d;
    logic        pool_vld;
    logic [3:0]  pool_idx;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    l1_pool_rd dut (
        .clk(clk), .rstn(rstn), .ConvValid_i(conv_valid), .start_i(start),
        .rd_en_o(rd_en), .rd_addr_o(rd_addr),
        .line0_d_i(line0_d), .line1_d_i(line1_d),
        .pool_d_o(pool_d), .pool_vld_o(pool_vld), .pool_idx_o(pool_idx),
        .busy_o(busy), .frame_done_o(frame_done), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    logic [15:0] mem0 [24];
    logic [15:0] mem1 [24];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fd_total = 0;

    int          log_cyc [$];
    logic [15:0] log_val [$];
    logic [3:0]  log_idx [$];
    logic        log_fd  [$];
    logic        rd_en_h [4096];
    logic [4:0]  addr_h  [4096];
    logic        busy_h  [4096];
    logic        ovr_h   [4096];
    logic        vld_h   [4096];

    // Line buffers return data one cycle after a read.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) begin
            line0_d <= mem0[rd_addr];
            line1_d <= mem1[rd_addr];
        end
    end

    // Output monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (cyc < 4096) begin
            rd_en_h[cyc] = rd_en;
            addr_h[cyc]  = rd_addr;
            busy_h[cyc]  = busy;
            ovr_h[cyc]   = overrun;
            vld_h[cyc]   = pool_vld;
        end
        if (frame_done) fd_total = fd_total + 1;
        if (pool_vld) begin
            log_cyc.push_back(cyc);
            log_val.push_back(pool_d);
            log_idx.push_back(pool_idx);
            log_fd.push_back(frame_done);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(output int t);
        start = 1'b1;
        t = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        log_cyc.delete();
        log_val.delete();
        log_idx.delete();
        log_fd.delete();
    endtask

    task automatic load_ramp();
        for (int a = 0; a < 24; a++) begin
            mem0[a] = 16'(a);
            mem1[a] = 16'(100 + a);
        end
    endtask

    // Checks 12 ramp outputs starting at log entry 'first' for a start at t0.
    task automatic check_ramp(input int t0, input int first);
        chk("ramp_count_min", 32'(log_cyc.size() >= first + 12), 32'd1);
        if (log_cyc.size() >= first + 12) begin
            for (int k = 0; k < 12; k++) begin
                chk("ramp_cycle", 32'(log_cyc[first + k]), 32'(t0 + 4 + 2 * k));
                chk("ramp_value", {16'd0, log_val[first + k]}, 32'(101 + 2 * k));
                chk("ramp_idx", {28'd0, log_idx[first + k]}, 32'(k));
            end
        end
    endtask

    int t;
    int t0;

    initial begin
        load_ramp();
        tick();
        chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("rst_addr", {27'd0, rd_addr}, 32'd0);
        chk("rst_pool", {16'd0, pool_d}, 32'd0);
        chk("rst_flags", {27'd0, pool_vld, pool_idx == 4'd0, busy, frame_done, overrun}, 32'h8);
        rstn = 1'b1;
        conv_valid = 1'b1;
        repeat (3) tick();

        // Ramp pair with read-side timing.
        clear_log();
        pulse_start(t);
        repeat (30) tick();
        chk("ramp_total", 32'(log_cyc.size()), 32'd12);
        check_ramp(t, 0);
        chk("busy_t0", {31'd0, busy_h[t]}, 32'd0);
        chk("busy_t1", {31'd0, busy_h[t + 1]}, 32'd1);
        chk("busy_t25", {31'd0, busy_h[t + 25]}, 32'd1);
        chk("busy_t26", {31'd0, busy_h[t + 26]}, 32'd0);
        chk("rden_t1", {26'd0, rd_en_h[t + 1], addr_h[t + 1]}, 32'h20);
        chk("rden_t24", {26'd0, rd_en_h[t + 24], addr_h[t + 24]}, 32'h37);
        chk("rden_t25", {31'd0, rd_en_h[t + 25]}, 32'd0);

        // Signed data: even columns win.
        for (int a = 0; a < 24; a += 2) begin
            mem0[a] = 16'hFFFB; mem1[a] = 16'hFFFD;
            mem0[a + 1] = 16'h8000; mem1[a + 1] = 16'hFFF9;
        end
        clear_log();
        pulse_start(t);
        repeat (30) tick();
        chk("signed_count", 32'(log_cyc.size()), 32'd12);
        for (int k = 0; k < 12 && k < log_cyc.size(); k++)
            chk("signed_value", {16'd0, log_val[k]}, 32'h0000FFFD);

        // Signed data: most-negative even columns, odd columns win via line0.
        for (int a = 0; a < 24; a += 2) begin
            mem0[a] = 16'h8000; mem1[a] = 16'h8000;
            mem0[a + 1] = 16'd7; mem1[a + 1] = 16'hFFF7;
        end
        clear_log();
        pulse_start(t);
        repeat (30) tick();
        chk("signed2_count", 32'(log_cyc.size()), 32'd12);
        for (int k = 0; k < 12 && k < log_cyc.size(); k++)
            chk("signed2_value", {16'd0, log_val[k]}, 32'd7);

        // Overrun: second start mid-readout is ignored.
        load_ramp();
        clear_log();
        pulse_start(t);
        repeat (9) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (25) tick();
        chk("ovr_count", 32'(log_cyc.size()), 32'd12);
        check_ramp(t, 0);
        chk("ovr_t10", {31'd0, ovr_h[t + 10]}, 32'd0);
        chk("ovr_t11", {31'd0, ovr_h[t + 11]}, 32'd1);
        chk("ovr_t34", {31'd0, ovr_h[t + 34]}, 32'd1);
        chk("ovr_rd_t26", {31'd0, rd_en_h[t + 27]}, 32'd0);

        // Abort via ConvValid low at T+12.
        clear_log();
        pulse_start(t);
        repeat (11) tick();
        conv_valid = 1'b0;
        tick();
        repeat (8) tick();
        chk("abort_count", 32'(log_cyc.size()), 32'd5);
        chk("abort_ovr_t12", {31'd0, ovr_h[t + 12]}, 32'd1);
        chk("abort_ovr_t13", {31'd0, ovr_h[t + 13]}, 32'd0);
        chk("abort_t13", {29'd0, rd_en_h[t + 13], vld_h[t + 13], busy_h[t + 13]}, 32'd0);
        chk("abort_t12_vld", {31'd0, vld_h[t + 12]}, 32'd1);
        conv_valid = 1'b1;
        tick();
        clear_log();
        pulse_start(t);
        repeat (30) tick();
        chk("abort_fresh_count", 32'(log_cyc.size()), 32'd12);
        check_ramp(t, 0);

        // Frame of 26 back-to-back pairs.
        conv_valid = 1'b0;
        tick();
        conv_valid = 1'b1;
        tick();
        clear_log();
        fd_total = 0;
        for (int p = 0; p < 26; p++) begin
            pulse_start(t);
            if (p == 0) t0 = t;
            repeat (25) tick();
        end
        repeat (6) tick();
        chk("frame_count", 32'(log_cyc.size()), 32'd312);
        chk("frame_fd_total", 32'(fd_total), 32'd1);
        chk("frame_no_ovr", {31'd0, overrun}, 32'd0);
        check_ramp(t0, 0);
        check_ramp(t0 + 26, 12);
        if (log_cyc.size() == 312) begin
            for (int i = 0; i < 312; i++) begin
                chk("frame_idx", {28'd0, log_idx[i]}, 32'(i % 12));
                chk("frame_cyc", 32'(log_cyc[i]), 32'(t0 + 26 * (i / 12) + 4 + 2 * (i % 12)));
                chk("frame_fd", {31'd0, log_fd[i]}, 32'(i == 311));
            end
        end

        // Counter restarted: next pair does not end a frame.
        fd_total = 0;
        clear_log();
        pulse_start(t);
        repeat (30) tick();
        chk("restart_fd", 32'(fd_total), 32'd0);
        check_ramp(t, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/l1_pool_rd.md
# l1_pool_rd

Layer-1 2x2 max-pool readout stage, directly downstream of the layer-1 row-splice/pool-line controller. When the controller signals that a pair of conv output lines sits in pool line buffers 0 and 1, this block reads both 24-entry lines in lockstep and forms 2x2 signed maxima, producing 12 pooled values per line pair. It also tracks line pairs per frame (26) and flags a start that arrives while a readout is still in progress.

## Interface
- `DW`, 16: signed data width of a line-buffer entry and of the pooled output.
- `LINE_LEN`, 24: entries per line; must be even.
- `PAIRS`, 26: line pairs per frame.
- `clk`  in  1  clock.
- `rstn`  in  1  reset; asynchronous, active-low.
- `ConvValid_i`  in  1  layer-1 conv active; low acts as a synchronous clear.
- `start_i`  in  1  single-cycle pulse: line pair complete (upstream vbit).
- `rd_en_o`  out  1  read enable to both pool line buffers.
- `rd_addr_o`  out  5  read address, shared by both buffers.
- `line0_d_i`  in  DW  line buffer 0 read data; valid 1 cycle after `rd_en_o`.
- `line1_d_i`  in  DW  line buffer 1 read data; valid 1 cycle after `rd_en_o`.
- `pool_d_o`  out  DW  pooled value.
- `pool_vld_o`  out  1  `pool_d_o` valid; single-cycle pulse per value; no backpressure.
- `pool_idx_o`  out  4  output column, 0..11.
- `busy_o`  out  1  readout in progress.
- `frame_done_o`  out  1  pulse coincident with the last output of pair `PAIRS-1`.
- `overrun_o`  out  1  sticky: `start_i` was seen while busy.

## Operation
- FSM states:
  - IDLE.
  - READ: issues addresses 0..LINE_LEN-1, one per cycle, with `rd_en_o`=1.
  - DRAIN: one cycle; the last read data returns.
- Transitions: IDLE→READ on `start_i & ConvValid_i`; READ→DRAIN after address LINE_LEN-1; DRAIN→IDLE.
- `start_i` is accepted only in IDLE.
- `start_i` in READ or DRAIN is ignored and sets `overrun_o`.
- Vertical max: `v = max(line0_d_i, line1_d_i)`, signed two's-complement compare. Ties pick either value (the results are equal).
- Even address: register `v` into a hold register.
- Odd address `a`:
  - `pool_d_o` ← max(hold, v).
  - `pool_idx_o` ← (a-1)/2.
  - `pool_vld_o` pulses.
- Pair counter, 0..PAIRS-1:
  - Increments on the output with idx 11.
  - At PAIRS-1 it wraps to 0 and `frame_done_o` pulses in the same cycle.
- `ConvValid_i`=0, in any state, takes effect at the next edge:
  - FSM goes to IDLE.
  - Pipeline valids, hold register, pair counter and `overrun_o` clear.
  - `pool_vld_o`, `frame_done_o` and `rd_en_o` are 0 from the following cycle.
- Reset values are all 0: every output, the FSM (IDLE), the counters and the hold register.
- `pool_d_o` and `pool_idx_o` hold their last value when `pool_vld_o`=0.

## Timing
- `start_i` high in cycle T, while in IDLE:
  - `busy_o`=1 in cycles T+1..T+25.
  - `rd_en_o`=1 in T+1..T+24, with `rd_addr_o` = cycle−(T+1).
  - Data for address `a` is sampled in cycle T+2+a.
  - `pool_vld_o` is high in T+3+a for odd `a`, i.e. T+4, T+6, …, T+26. Latency from start to first output is 4 cycles.
- Back-to-back operation:
  - The earliest accepted next start is cycle T+26 (IDLE).
  - It overlaps the final output of the previous pair without conflict.
  - Its first read is at T+27.
- `frame_done_o` shares its cycle with the final `pool_vld_o` of the frame.
- `overrun_o` rises the cycle after the offending `start_i`.
- `overrun_o` clears only on reset or on `ConvValid_i`=0.

## Structure
- Shared package `l1_pool_pkg` holds:
  - `DW`, `LINE_LEN`, `PAIRS`.
  - The FSM state enum (IDLE, READ, DRAIN).
  - The pooled-column width constant.
- Sub-module `l1_smax2`: combinational signed 2-input max. Instantiate it twice: vertical and horizontal.
- Address, pair counter and output registers live in the top module.
- Target size is about 150–250 lines.

## Test plan
- Ramp pair:
  - Stimulus: line0[a]=a, line1[a]=100+a; start at T.
  - Required: 12 outputs at T+4..T+26 (even offsets) with value 101+2k, idx k.
- Signed data:
  - Stimulus: line0 = −5, line1 = −3 alternating with 0x8000; entries 0/1 = {−5,−3} and {0x8000, −7}.
  - Required: output 0 = −3; negative extremes never win over larger values.
- Overrun:
  - Stimulus: second `start_i` at T+10.
  - Required: ignored; reads are unchanged; `overrun_o`=1 from T+11 and stays high.
- Abort:
  - Stimulus: `ConvValid_i` low at T+12.
  - Required: IDLE, `rd_en_o`=0 and `pool_vld_o`=0 from T+13; a fresh start later yields a clean idx 0..11 sequence.
- Frame:
  - Stimulus: 26 accepted starts.
  - Required: `frame_done_o` pulses once, with the 312th output; the pair counter then restarts at 0.
- Back-to-back:
  - Stimulus: starts at T and T+26.
  - Required: 24 outputs, contiguous idx sequences, no overrun.
